// File: rtl/sd_init_seq.sv
// SD card SPI-mode power-up sequencer: dummy clocks, CMD0/8/55/ACMD41/58 handshake, status flags.
// Optional CMD59 (CRC enable) step is compiled in with `define SD_INIT_CRC_EN.
module sd_init_seq #(
  parameter int         DUMMY_FRAMES = 2,
  parameter int         RETRY_MAX    = 255,
  parameter int         TIMEOUT_CYC  = 4096,
  parameter logic [2:0] DIV_INIT     = 3'b010,
  parameter logic [2:0] DIV_RUN      = 3'b000
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        start_i,
  input  logic        cmd_ready_i,
  input  logic        resp_valid_i,
  input  logic [7:0]  resp_r1_i,
  input  logic [31:0] resp_ext_i,
  output logic [47:0] frame_o,
  output logic        cmd_valid_o,
  output logic        cs_n_o,
  output logic [2:0]  clkdiv_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic        sdhc_o,
  output logic        v2_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ERR_CMD0  = 3'd1;
  localparam logic [2:0] ERR_CMD8  = 3'd2;
  localparam logic [2:0] ERR_ACMD  = 3'd3;
  localparam logic [2:0] ERR_CMD58 = 3'd4;
  localparam logic [2:0] ERR_TMO   = 3'd6;

  localparam logic [47:0] F_ONES  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD55 = 48'h77_0000_0000_65;
  localparam logic [47:0] F_CMD58 = 48'h7A_0000_0000_FD;

  typedef enum logic [3:0] {
    S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_DONE, S_ERR
`ifdef SD_INIT_CRC_EN
    , S_CMD59
`endif
  } state_t;

`ifdef SD_INIT_CRC_EN
  localparam logic [2:0]  ERR_CMD59 = 3'd5;
  localparam logic [47:0] F_CMD59   = 48'h7B_0000_0001_83;
  localparam state_t      POST_OCR  = S_CMD59;
`else
  localparam state_t      POST_OCR  = S_DONE;
`endif

  // CRC7 (x^7 + x^3 + 1) over the 40 leading frame bits, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic            wait_q, wait_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [7:0]      dummy_q, dummy_d;
  logic [7:0]      cmd0_q, cmd0_d;
  logic [7:0]      acmd_q, acmd_d;
  logic            v2_q, v2_d;
  logic            sdhc_q, sdhc_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            timeout;
  logic [39:0]     acmd41_body;
  logic            unused_ext;

  assign unused_ext  = ^{resp_ext_i[31], resp_ext_i[29:12]};
  assign acmd41_body = {8'h69, 1'b0, v2_q, 30'b0};
  assign timeout     = wait_q && (wcnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      wcnt_q      <= '0;
      dummy_q     <= '0;
      cmd0_q      <= '0;
      acmd_q      <= '0;
      v2_q        <= 1'b0;
      sdhc_q      <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cmd_valid_q <= cmd_valid_d;
      wcnt_q      <= wcnt_d;
      dummy_q     <= dummy_d;
      cmd0_q      <= cmd0_d;
      acmd_q      <= acmd_d;
      v2_q        <= v2_d;
      sdhc_q      <= sdhc_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cmd_valid_d = 1'b0;
    wcnt_d      = wcnt_q;
    dummy_d     = dummy_q;
    cmd0_d      = cmd0_q;
    acmd_d      = acmd_q;
    v2_d        = v2_q;
    sdhc_d      = sdhc_q;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_DUMMY;
          wait_d     = 1'b0;
          wcnt_d     = '0;
          dummy_d    = '0;
          cmd0_d     = '0;
          acmd_d     = '0;
          v2_d       = 1'b0;
          sdhc_d     = 1'b0;
          err_code_d = '0;
        end
      end
      default: begin
        if (!wait_q) begin
          // ISSUE: valid rises one cycle after entry, drops after the transfer
          if (cmd_valid_q && cmd_ready_i) begin
            wait_d = 1'b1;
            wcnt_d = '0;
          end else begin
            cmd_valid_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + TW'(1);
          if (timeout) begin
            wait_d     = 1'b0;
            state_d    = S_ERR;
            err_code_d = ERR_TMO;
          end else if (resp_valid_i) begin
            // every response leaves WAIT: either re-issue this command or move on
            wait_d = 1'b0;
            case (state_q)
              S_DUMMY: begin
                if ({1'b0, dummy_q} + 9'd1 >= 9'(DUMMY_FRAMES)) state_d = S_CMD0;
                else dummy_d = dummy_q + 8'd1;
              end
              S_CMD0: begin
                if (resp_r1_i == 8'h01) begin
                  state_d = S_CMD8;
                end else if ({1'b0, cmd0_q} + 9'd1 >= 9'(RETRY_MAX)) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_CMD0;
                end else begin
                  cmd0_d = cmd0_q + 8'd1;
                end
              end
              S_CMD8: begin
                if (resp_r1_i == 8'h01 && resp_ext_i[11:0] == 12'h1AA) begin
                  v2_d    = 1'b1;
                  state_d = S_CMD55;
                end else if (resp_r1_i[2]) begin
                  v2_d    = 1'b0;
                  state_d = S_CMD55;
                end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_CMD8;
                end
              end
              S_CMD55: begin
                if (resp_r1_i == 8'h00 || resp_r1_i == 8'h01) begin
                  state_d = S_ACMD41;
                end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_ACMD;
                end
              end
              S_ACMD41: begin
                if (resp_r1_i == 8'h00) begin
                  state_d = v2_q ? S_CMD58 : POST_OCR;
                end else if (resp_r1_i == 8'h01 &&
                             {1'b0, acmd_q} + 9'd1 < 9'(RETRY_MAX)) begin
                  acmd_d  = acmd_q + 8'd1;
                  state_d = S_CMD55;
                end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_ACMD;
                end
              end
              S_CMD58: begin
                if (resp_r1_i == 8'h00) begin
                  sdhc_d  = resp_ext_i[30];
                  state_d = POST_OCR;
                end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_CMD58;
                end
              end
`ifdef SD_INIT_CRC_EN
              S_CMD59: begin
                if (resp_r1_i == 8'h00) begin
                  state_d = S_DONE;
                end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_CMD59;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    frame_o = F_ONES;
    case (state_q)
      S_CMD0:   frame_o = F_CMD0;
      S_CMD8:   frame_o = F_CMD8;
      S_CMD55:  frame_o = F_CMD55;
      S_ACMD41: frame_o = {acmd41_body, crc7(acmd41_body), 1'b1};
      S_CMD58:  frame_o = F_CMD58;
`ifdef SD_INIT_CRC_EN
      S_CMD59:  frame_o = F_CMD59;
`endif
      default:  frame_o = F_ONES;
    endcase
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cs_n_o      = (state_q == S_IDLE) || (state_q == S_DUMMY) ||
                       (state_q == S_DONE) || (state_q == S_ERR);
  assign clkdiv_o    = (state_q == S_DONE) ? DIV_RUN : DIV_INIT;
  assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign err_code_o  = err_code_q;
  assign sdhc_o      = sdhc_q;
  assign v2_o        = v2_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq: a card responder answers each frame, expected frame
// sequences and final status come from a scenario-level model of the init protocol.
module tb_sd_init_seq;

  localparam int         RETRY  = 4;
  localparam int         TMO    = 16;
  localparam int         NDUMMY = 2;
  localparam logic [2:0] DINIT  = 3'b010;
  localparam logic [2:0] DRUN   = 3'b000;

  localparam logic [47:0] F_DUMMY = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD55 = 48'h77_0000_0000_65;
  localparam logic [47:0] F_A41H  = 48'h69_4000_0000_77;
  localparam logic [47:0] F_A410  = 48'h69_0000_0000_E5;
  localparam logic [47:0] F_CMD58 = 48'h7A_0000_0000_FD;
  localparam logic [47:0] F_CMD59 = 48'h7B_0000_0001_83;

  logic        clk = 1'b0;
  logic        spi_rst_i, start_i, cmd_ready_i, resp_valid_i;
  logic [7:0]  resp_r1_i;
  logic [31:0] resp_ext_i;
  logic [47:0] frame_o;
  logic        cmd_valid_o, cs_n_o, busy_o, done_o, err_o, sdhc_o, v2_o;
  logic [2:0]  clkdiv_o, err_code_o;

  sd_init_seq #(
    .DUMMY_FRAMES(NDUMMY), .RETRY_MAX(RETRY), .TIMEOUT_CYC(TMO),
    .DIV_INIT(DINIT), .DIV_RUN(DRUN)
  ) dut (
    .spi_clk_i(clk), .spi_rst_i(spi_rst_i), .start_i(start_i),
    .cmd_ready_i(cmd_ready_i), .resp_valid_i(resp_valid_i),
    .resp_r1_i(resp_r1_i), .resp_ext_i(resp_ext_i),
    .frame_o(frame_o), .cmd_valid_o(cmd_valid_o), .cs_n_o(cs_n_o),
    .clkdiv_o(clkdiv_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .sdhc_o(sdhc_o), .v2_o(v2_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] frame;
    logic        cs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // card behaviour for the current scenario
  int c_v2 = 1, c_ccs = 0, c_cmd0_fails = 0, c_busy = 0, c_cmd59_r1 = 0;
  int c_tmode = 0, c_stall = 0, scen_id = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [47:0] f, input logic cs);
    exp_t e;
    e.frame = f;
    e.cs    = cs;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     48'(busy_o),      48'd0);
    check({tag, "_cs_n"},     48'(cs_n_o),      48'd1);
    check({tag, "_frame"},    frame_o,          F_DUMMY);
    check({tag, "_clkdiv"},   48'(clkdiv_o),    48'(DINIT));
    check({tag, "_valid"},    48'(cmd_valid_o), 48'd0);
    check({tag, "_done"},     48'(done_o),      48'd0);
    check({tag, "_err"},      48'(err_o),       48'd0);
    check({tag, "_err_code"}, 48'(err_code_o),  48'd0);
    check({tag, "_v2"},       48'(v2_o),        48'd0);
    check({tag, "_sdhc"},     48'(sdhc_o),      48'd0);
  endtask

  // monitor: every accepted frame is popped from the scoreboard and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!spi_rst_i && cmd_valid_o && cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h expected none", frame_o);
        end else begin
          e = exp_q.pop_front();
          check("frame", frame_o, e.frame);
          check("cs_n_at_frame", 48'(cs_n_o), 48'(e.cs));
        end
      end
    end
  end

  // ready driver: random (or forced) stall, frame must hold while stalled
  initial begin
    int          n;
    logic        ok;
    logic [47:0] f0;
    cmd_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready_i = 1'b0;
      if (cmd_valid_o && !spi_rst_i) begin
        n  = (c_stall > 0) ? c_stall : int'($urandom_range(0, 2));
        f0 = frame_o;
        ok = 1'b1;
        repeat (n) begin
          @(posedge clk);
          #1;
          if (!cmd_valid_o || frame_o !== f0) ok = 1'b0;
        end
        if (n > 0) check("hold_stable", 48'(ok), 48'd1);
        cmd_ready_i = 1'b1;
      end
    end
  end

  // card responder
  initial begin
    int          last_id, n0, n41, lat, cyc;
    logic        give;
    logic [5:0]  idx;
    logic [7:0]  r1;
    logic [31:0] ext;
    resp_valid_i = 1'b0;
    resp_r1_i    = '0;
    resp_ext_i   = '0;
    last_id = -1;
    n0  = 0;
    n41 = 0;
    forever begin
      @(negedge clk);
      if (last_id != scen_id) begin
        last_id = scen_id;
        n0  = 0;
        n41 = 0;
      end
      if (!spi_rst_i && cmd_valid_o && cmd_ready_i) begin
        idx  = frame_o[45:40];
        lat  = int'($urandom_range(1, TMO - 1));
        give = 1'b1;
        r1   = 8'hFF;
        ext  = $urandom;
        case (idx)
          6'd0: begin
            if (c_tmode == 1) give = 1'b0;
            else if (c_tmode == 2) lat = TMO;
            r1 = (n0 < c_cmd0_fails) ? 8'h00 : 8'h01;
            n0++;
          end
          6'd8: begin
            if (c_v2 == 1) begin
              r1 = 8'h01; ext = 32'h0000_01AA;
            end else if (c_v2 == 0) begin
              r1 = 8'h05;
            end else begin
              r1 = 8'h01; ext = 32'h0000_01AB;
            end
          end
          6'd55: r1 = 8'h01;
          6'd41: begin
            r1 = (n41 < c_busy) ? 8'h01 : 8'h00;
            n41++;
          end
          6'd58: begin
            r1  = 8'h00;
            ext = (c_ccs != 0) ? 32'hC0FF_8000 : 32'h80FF_8000;
          end
          6'd59: r1 = 8'(c_cmd59_r1);
          default: r1 = 8'hFF;
        endcase
        @(posedge clk);
        if (give) begin
          repeat (lat - 1) @(posedge clk);
          #1;
          resp_valid_i = 1'b1;
          resp_r1_i    = r1;
          resp_ext_i   = ext;
          @(posedge clk);
          #1;
          resp_valid_i = 1'b0;
        end else begin
          cyc = 0;
          while (cyc < 40 && !err_o) begin
            @(posedge clk);
            #1;
            cyc++;
          end
          check("timeout_latency", 48'(cyc), 48'(TMO));
        end
      end
    end
  end

  // builds the expected frame list from the card behaviour, runs, then checks final status
  task automatic run(input int v2m, input int ccs, input int f0, input int busy,
                     input int r59, input int tmode, input int stall, input string tag);
    int   exp_err, k, n0a, npair;
    logic ev2, esdhc;
    c_v2 = v2m; c_ccs = ccs; c_cmd0_fails = f0; c_busy = busy;
    c_cmd59_r1 = r59; c_tmode = tmode; c_stall = stall;
    scen_id++;
    exp_q.delete();
    for (int i = 0; i < NDUMMY; i++) push(F_DUMMY, 1'b1);
    ev2 = 1'b0; esdhc = 1'b0; exp_err = 0;
    if (tmode != 0) begin
      push(F_CMD0, 1'b0);
      exp_err = 6;
    end else begin
      n0a = (f0 >= RETRY) ? RETRY : f0 + 1;
      repeat (n0a) push(F_CMD0, 1'b0);
      if (f0 >= RETRY) exp_err = 1;
      else begin
        push(F_CMD8, 1'b0);
        if (v2m == 2) exp_err = 2;
        else begin
          ev2   = (v2m == 1);
          npair = (busy >= RETRY) ? RETRY : busy + 1;
          repeat (npair) begin
            push(F_CMD55, 1'b0);
            push(ev2 ? F_A41H : F_A410, 1'b0);
          end
          if (busy >= RETRY) exp_err = 3;
          else begin
            if (ev2) begin
              push(F_CMD58, 1'b0);
              esdhc = (ccs != 0);
            end
`ifdef SD_INIT_CRC_EN
            push(F_CMD59, 1'b0);
            if (r59 != 0) exp_err = 5;
`endif
          end
        end
      end
    end
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "_busy_after_start"}, 48'(busy_o), 48'd1);
    check({tag, "_err_cleared"},      48'(err_o),  48'd0);
    k = 0;
    while (!(done_o || err_o) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_finished_in_bound"}, 48'(k < 3000), 48'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done"},     48'(done_o),     48'(exp_err == 0));
    check({tag, "_err"},      48'(err_o),      48'(exp_err != 0));
    check({tag, "_err_code"}, 48'(err_code_o), 48'(exp_err));
    check({tag, "_v2"},       48'(v2_o),       48'(ev2));
    check({tag, "_sdhc"},     48'(sdhc_o),     48'(esdhc));
    check({tag, "_clkdiv"},   48'(clkdiv_o),   48'((exp_err == 0) ? DRUN : DINIT));
    check({tag, "_cs_n"},     48'(cs_n_o),     48'd1);
    check({tag, "_busy"},     48'(busy_o),     48'd0);
    check({tag, "_frames_left"}, 48'(exp_q.size()), 48'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    spi_rst_i = 1'b1;
    start_i   = 1'b0;
    #2;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    spi_rst_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 48'(busy_o), 48'd0);
    check("idle_valid", 48'(cmd_valid_o), 48'd0);

    run(1, 1, 0, 2,   0, 0, 0,  "sdhc");
    run(0, 0, 0, 0,   0, 0, 0,  "v1");
    run(1, 0, 0, 255, 0, 0, 0,  "acmd_busy");
    run(1, 0, 0, 0,   0, 1, 0,  "timeout");
    run(1, 1, 1, 1,   0, 2, 0,  "late_resp");
    run(2, 0, 0, 0,   0, 0, 0,  "cmd8_bad");
    run(1, 0, 10, 0,  0, 0, 0,  "cmd0_fail");
    run(1, 1, 0, 1,   0, 0, 10, "stall");
    run(1, 0, 0, 3,   0, 0, 0,  "busy_max_ok");
`ifdef SD_INIT_CRC_EN
    run(1, 1, 0, 0,   4, 0, 0,  "cmd59_bad");
`endif
    for (int i = 0; i < 10; i++)
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          0, 0, 0, "rand");

    // asynchronous reset while waiting for the ACMD41 response
    c_v2 = 1; c_busy = 255; c_cmd0_fails = 0; c_tmode = 0; c_stall = 0;
    scen_id++;
    exp_q.delete();
    for (int i = 0; i < NDUMMY; i++) push(F_DUMMY, 1'b1);
    push(F_CMD0, 1'b0);
    push(F_CMD8, 1'b0);
    push(F_CMD55, 1'b0);
    push(F_A41H, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_acmd41", 48'(k < 3000), 48'd1);
    if (cmd_valid_o) @(posedge clk);
    #1;
    check("rst_in_wait_busy", 48'(busy_o), 48'd1);
    spi_rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    spi_rst_i = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_resume_busy",  48'(busy_o),      48'd0);
    check("no_resume_valid", 48'(cmd_valid_o), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 Parameter DUMMY_FRAMES, default 2: number of 48-bit all-ones frames sent with CS high before CMD0 (2 frames = 96 SCK, which meets the 74-SCK minimum).
REQ-002 Parameter RETRY_MAX, default 255: maximum CMD0 attempts and maximum CMD55/ACMD41 loop iterations.
REQ-003 Parameter TIMEOUT_CYC, default 4096: maximum spi_clk_i cycles allowed from frame acceptance to response.
REQ-004 Parameter DIV_INIT, default 3'b010: clock-divider code driven while the sequence runs.
REQ-005 Parameter DIV_RUN, default 3'b000: clock-divider code driven once DONE is reached.
REQ-006 spi_clk_i  in  1  system clock; all state updates on its rising edge.
REQ-007 spi_rst_i  in  1  asynchronous, active-high reset.
REQ-008 start_i  in  1  single-cycle pulse that begins the sequence; ignored while busy_o=1.
REQ-009 cmd_ready_i  in  1  SPI engine accepts the frame on frame_o.
REQ-010 resp_valid_i  in  1  single-cycle pulse marking a completed transfer, with its response captured.
REQ-011 resp_r1_i  in  8  R1 byte.
REQ-012 resp_ext_i  in  32  trailing R7/R3 bytes, MSB first.
REQ-013 frame_o  out  48  command frame: start bits, index, argument, CRC7 and end bit.
REQ-014 cmd_valid_o  out  1  frame_o is valid.
REQ-015 cs_n_o  out  1  card chip select, active low.
REQ-016 clkdiv_o  out  3  clock-divider code for the SPI engine.
REQ-017 busy_o / done_o / err_o  out  1 each  sequence status flags.
REQ-018 err_code_o  out  3  failure cause (see REQ-029).
REQ-019 sdhc_o  out  1  set to OCR bit 30 (CCS) by CMD58.
REQ-020 v2_o  out  1  card answered CMD8 with a valid echo.

Function
REQ-021 The states SHALL be IDLE, DUMMY, CMD0, CMD8, CMD55, ACMD41, CMD58, CMD59, DONE and ERR; each command state has an ISSUE phase and a WAIT phase.
REQ-022 Handshake: cmd_valid_o rises on the cycle after a state is entered, frame_o stays stable while cmd_valid_o=1, and a transfer occurs on the first cycle with cmd_valid_o&cmd_ready_i=1.
REQ-023 On that transfer cycle, cmd_valid_o SHALL drop on the next cycle and the block enters WAIT; resp_valid_i is honoured only in WAIT.
REQ-024 DUMMY: send DUMMY_FRAMES frames of 48'hFFFFFFFFFFFF with cs_n_o=1, ignore response content, then go to CMD0; cs_n_o=0 in every later state up to DONE/ERR.
REQ-025 CMD0 (48'h400000000095): R1=8'h01 goes to CMD8; any other R1 re-issues CMD0; after RETRY_MAX attempts go to ERR with code 1.
REQ-026 CMD8 (48'h48000001AA87): R1=8'h01 with resp_ext_i[11:0]=12'h1AA sets v2_o=1 and goes to CMD55.
REQ-026a CMD8: R1 bit 2 set (illegal command) sets v2_o=0 and goes to CMD55.
REQ-026b CMD8: any other response goes to ERR with code 2.
REQ-027 CMD55 (48'h770000000065): R1 equal to 8'h00 or 8'h01 goes to ACMD41; any other R1 goes to ERR with code 3.
REQ-027a ACMD41: frame is {8'h69, 1'b0, v2_o, 30'b0, CRC7, 1'b1} with CRC7 computed combinationally; R1=8'h00 goes to CMD58 if v2_o=1, else to the post-OCR step (REQ-028a).
REQ-027b ACMD41: R1=8'h01 increments an 8-bit retry counter and returns to CMD55; when the counter equals RETRY_MAX go to ERR with code 3; any other R1 goes to ERR with code 3.
REQ-028 CMD58 (48'h7A00000000FD): R1=8'h00 latches sdhc_o=resp_ext_i[30] and goes to the post-OCR step; any other R1 goes to ERR with code 4.
REQ-028a Post-OCR step: go to CMD59 when configured in (REQ-036), otherwise to DONE.
REQ-029 err_code_o values: 1 CMD0, 2 CMD8, 3 ACMD41 or CMD55, 4 CMD58, 5 CMD59, 6 timeout; 0 when no error.
REQ-030 A WAIT counter reaching TIMEOUT_CYC with no resp_valid_i SHALL force ERR with code 6; this check has priority over all other WAIT transitions.
REQ-030a The WAIT counter SHALL clear on entry to every WAIT phase.
REQ-031 clkdiv_o=DIV_INIT in every state except DONE, where it is DIV_RUN.
REQ-031a busy_o=1 in every state except IDLE, DONE and ERR.
REQ-032 DONE: done_o=1 and cs_n_o=1, held until reset or start_i.
REQ-032a ERR: err_o=1 and cs_n_o=1, held until reset or start_i.
REQ-033 start_i in IDLE, DONE or ERR SHALL clear done_o, err_o, err_code_o, v2_o, sdhc_o and all counters, then enter DUMMY.
REQ-033a Any response that arrives in the same cycle as the timeout is discarded (REQ-030 priority applies).

Reset
REQ-034 On spi_rst_i (asynchronous), the state SHALL be IDLE and every output SHALL be 0, except cs_n_o=1, frame_o=48'hFFFFFFFFFFFF and clkdiv_o=DIV_INIT.
REQ-035 Reset asserted mid-transfer SHALL abort immediately; the sequence is not resumed on release.

Configuration
REQ-036 SD_INIT_CRC_EN defined: the CMD59 state is compiled in and issues 48'h7B0000000183; R1=8'h00 goes to DONE, any other R1 goes to ERR with code 5.
REQ-036a SD_INIT_CRC_EN undefined: the CMD59 state and code 5 are absent, and the post-OCR step goes straight to DONE.

Verification
REQ-037 v2 SDHC card model (CMD0 gives 01, CMD8 gives 01/000001AA, ACMD41 gives 01 twice then 00, CMD58 gives 00/C0FF8000) -> done_o=1, v2_o=1, sdhc_o=1, clkdiv_o=DIV_RUN, exactly 2 dummy frames sent with cs_n_o=1.
REQ-038 CMD8 answered with R1=8'h05 -> v2_o=0, ACMD41 argument bit 30 is 0, CMD58 is skipped, done_o=1.
REQ-039 ACMD41 answers 8'h01 forever with RETRY_MAX=4 -> err_o=1, err_code_o=3 after the 4th ACMD41 transfer.
REQ-040 resp_valid_i withheld after CMD0 with TIMEOUT_CYC=16 -> err_code_o=6 on cycle 16 of WAIT; a later start_i restarts the sequence and clears err_o.
REQ-041 cmd_ready_i held low for 10 cycles -> cmd_valid_o stays 1 and frame_o stays constant throughout.
REQ-041a spi_rst_i pulsed during ACMD41 WAIT -> IDLE with reset output values on the same edge.
REQ-042 With SD_INIT_CRC_EN defined, CMD59 answered with 8'h04 -> err_code_o=5; without the macro, no CMD59 frame is observed.
